// File: rtl/mandel_timer_ctrl.sv
// Avalon-MM control slave and cycle timer for the Mandelbrot solver array.
// Issues a one-cycle compute_start, then counts cycles until compute_done.
module mandel_timer_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic             read,
  output logic [31:0]      readdata,
  input  logic             compute_done,
  output logic             compute_start,
  output logic             busy,
  output logic [CNT_W-1:0] elapsed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;
  logic             r_done;
  logic             r_ovf;
  logic             r_busy;
  logic             r_start;
  logic [31:0]      r_readdata;

  logic w_ctrl_wr;
  logic w_start;
  logic w_abort;
  logic w_ack;
  logic w_unused;

  // Read latency is fixed, so the read strobe and upper CTRL bits carry no meaning here.
  assign w_unused  = &{read, writedata[31:3]};
  assign w_ctrl_wr = write && (address == 2'd0);
  assign w_start   = w_ctrl_wr && writedata[0];
  assign w_abort   = w_ctrl_wr && writedata[1];
  assign w_ack     = w_ctrl_wr && writedata[2];

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_n = S_START;
      S_START: w_state_n = S_RUN;
      S_RUN:   if (compute_done) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    if (w_abort) w_state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n != S_IDLE);
      r_start <= (w_state_n == S_START);

      // An abort freezes the count where it stands, even on a RUN cycle.
      if (r_state == S_IDLE && w_start && !w_abort) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == S_RUN && !w_abort) begin
        if (r_cnt == {CNT_W{1'b1}}) r_ovf <= 1'b1;
        else                        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == S_DONE && !w_abort) r_last <= r_cnt;

      if (r_state == S_IDLE && w_start && !w_abort) r_done <= 1'b0;
      else if (r_state == S_DONE && !w_abort)       r_done <= 1'b1;
      else if (w_ack)                               r_done <= 1'b0;

      case (address)
        2'd1:    r_readdata <= {29'b0, r_ovf, r_done, r_busy};
        2'd2:    r_readdata <= 32'(r_cnt);
        2'd3:    r_readdata <= 32'(r_last);
        default: r_readdata <= '0;
      endcase
    end
  end

  assign readdata      = r_readdata;
  assign compute_start = r_start;
  assign busy          = r_busy;
  assign elapsed       = r_cnt;

endmodule
